// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
//
// Shared definitions for the chunk_mac_neuron slice.
//
// Contents
//    - default width constants for the neuron datapath
//    - state_t : FSM state encoding (IDLE=0, RUN=1, OUT=2)
//    - sat_relu : converts a final accumulator value into the neuron result
//
// Configuration macro
//    NEURON_RELU_EN : when defined, sat_relu applies a ReLU and clamps to the
//                     unsigned OUT_WIDTH range; when undefined it saturates to
//                     the signed two's-complement OUT_WIDTH range.
// ---------------------------------------------------------------------------
package neuron_pkg;

   localparam int DATA_WIDTH_DEF   = 4;
   localparam int NUM_INPUTS_DEF   = 8;
   localparam int WEIGHT_WIDTH_DEF = 8;
   localparam int ACC_WIDTH_DEF    = 20;
   localparam int OUT_WIDTH_DEF    = 8;

   // sat_relu works on a fixed-width container so that any accumulator up to
   // SAT_ACC_W bits and any result up to SAT_OUT_W bits can share one function.
   // Callers sign-extend the accumulator in and keep the low result bits.
   localparam int SAT_ACC_W = 32;
   localparam int SAT_OUT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Maps a signed accumulator onto the out_w-bit neuron result. The limits
   // are built from out_w at run time so the same function serves any result
   // width up to SAT_OUT_W.
   function automatic logic [SAT_OUT_W-1:0] sat_relu(
      input logic signed [SAT_ACC_W-1:0] acc,
      input int                          out_w
   );
      logic signed [SAT_ACC_W-1:0] hi;
      logic [SAT_OUT_W-1:0]        res;
`ifdef NEURON_RELU_EN
      hi = (SAT_ACC_W'(1) << out_w) - 1;
      if (acc < 0) begin
         res = '0;
      end else if (acc > hi) begin
         res = hi[SAT_OUT_W-1:0];
      end else begin
         res = acc[SAT_OUT_W-1:0];
      end
`else
      logic signed [SAT_ACC_W-1:0] lo;
      hi = (SAT_ACC_W'(1) << (out_w - 1)) - 1;
      lo = -hi - 1;
      if (acc > hi) begin
         res = hi[SAT_OUT_W-1:0];
      end else if (acc < lo) begin
         res = lo[SAT_OUT_W-1:0];
      end else begin
         res = acc[SAT_OUT_W-1:0];
      end
`endif
      return res;
   endfunction

endpackage

// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
//
// Multiply-accumulate slice of the neuron. Multiplies an unsigned activation
// chunk by a signed weight, sign-extends the product to the accumulator width
// and adds it into the accumulator register.
//
// Ports
//    clk        in   rising-edge clock
//    rst        in   asynchronous active-high reset, clears the accumulator
//    load_bias  in   loads the sign-extended bias (starts a new evaluation)
//    acc_en     in   adds the current product into the accumulator
//    bias       in   WEIGHT_WIDTH signed bias value
//    data       in   DATA_WIDTH unsigned activation chunk
//    weight     in   WEIGHT_WIDTH signed weight for this chunk
//    acc        out  ACC_WIDTH signed accumulator value
// ---------------------------------------------------------------------------
module mac_unit
   import neuron_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
   parameter int ACC_WIDTH    = ACC_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_bias,
   input  logic                    acc_en,
   input  logic [WEIGHT_WIDTH-1:0] bias,
   input  logic [DATA_WIDTH-1:0]   data,
   input  logic [WEIGHT_WIDTH-1:0] weight,
   output logic [ACC_WIDTH-1:0]    acc
);

   // One extra bit keeps the unsigned activation positive once it is treated
   // as a signed operand.
   localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH + 1;

   logic signed [PROD_WIDTH-1:0] data_ext;
   logic signed [PROD_WIDTH-1:0] weight_ext;
   logic signed [PROD_WIDTH-1:0] product;
   logic signed [ACC_WIDTH-1:0]  product_ext;
   logic signed [ACC_WIDTH-1:0]  bias_ext;

   // Both operands are widened to the full product width before the multiply
   // so the signed product is exact; it is then sign-extended to the
   // accumulator width, as is the bias.
   always_comb begin
      data_ext    = PROD_WIDTH'($signed({1'b0, data}));
      weight_ext  = PROD_WIDTH'($signed(weight));
      product     = data_ext * weight_ext;
      product_ext = ACC_WIDTH'(product);
      bias_ext    = ACC_WIDTH'($signed(bias));
   end

   // Accumulator register. Loading the bias takes priority over accumulating
   // because it marks the start of a fresh evaluation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (load_bias) begin
         acc <= bias_ext;
      end else if (acc_en) begin
         acc <= acc + product_ext;
      end
   end

endmodule

// File: rtl/chunk_mac_neuron.sv
// ---------------------------------------------------------------------------
// chunk_mac_neuron
//
// Pops NUM_INPUTS unsigned activation chunks from the upstream width-converting
// FIFO, multiplies each by a stored signed weight, accumulates the products on
// top of a stored bias and presents the activated/saturated result on a
// valid/ready output.
//
// Ports
//    clk         in   rising-edge clock
//    rst         in   asynchronous active-high reset
//    start       in   one-cycle pulse, begins an evaluation (IDLE only)
//    fifo_empty  in   FIFO empty flag
//    fifo_data   in   FIFO read data, valid the cycle after fifo_rd_en
//    fifo_rd_en  out  pop request to the FIFO
//    w_wr_en     in   weight/bias write strobe (IDLE only)
//    w_addr      in   0..NUM_INPUTS-1 selects a weight, NUM_INPUTS the bias
//    w_data      in   signed weight/bias value
//    result      out  neuron result, stable while out_valid
//    out_valid   out  result available, held until accepted
//    out_ready   in   consumer accepts the result
//    busy        out  high whenever the FSM is not in IDLE
//
// Configuration macro
//    NEURON_RELU_EN : selects ReLU + unsigned clamp instead of signed
//                     saturation for the result (implemented in neuron_pkg).
//
// ACC_WIDTH must be at least DATA_WIDTH+WEIGHT_WIDTH+1+clog2(NUM_INPUTS) and
// no wider than neuron_pkg::SAT_ACC_W; OUT_WIDTH must be below SAT_OUT_W.
// ---------------------------------------------------------------------------
module chunk_mac_neuron
   import neuron_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int NUM_INPUTS   = NUM_INPUTS_DEF,
   parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
   parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
   parameter int OUT_WIDTH    = OUT_WIDTH_DEF
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               fifo_empty,
   input  logic [DATA_WIDTH-1:0]              fifo_data,
   output logic                               fifo_rd_en,
   input  logic                               w_wr_en,
   input  logic [$clog2(NUM_INPUTS+1)-1:0]    w_addr,
   input  logic [WEIGHT_WIDTH-1:0]            w_data,
   output logic [OUT_WIDTH-1:0]               result,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               busy
);

   localparam int AW = $clog2(NUM_INPUTS + 1);
   localparam int IW = $clog2(NUM_INPUTS);

   state_t                  state;
   state_t                  state_next;

   logic [WEIGHT_WIDTH-1:0] weight_mem [NUM_INPUTS];
   logic [WEIGHT_WIDTH-1:0] bias_reg;
   logic [WEIGHT_WIDTH-1:0] bias_eff;
   logic [WEIGHT_WIDTH-1:0] cur_weight;

   logic [AW-1:0]           issue_cnt;
   logic [AW-1:0]           acc_cnt;
   logic                    rd_pend;

   logic                    wr_ok;
   logic                    wr_weight;
   logic                    wr_bias;
   logic                    run_entry;
   logic                    acc_done;

   logic [ACC_WIDTH-1:0]    acc;
   logic [SAT_OUT_W-1:0]    sat_full;
   logic                    unused_sat_bits;

   // Decode of the weight/bias write port and of the evaluation boundaries.
   // Writes are only honoured in IDLE; addresses above NUM_INPUTS match
   // neither the weight range nor the bias slot, so they fall through.
   // A bias write in the same cycle as start is forwarded straight into the
   // accumulator load so the evaluation already sees the new bias.
   always_comb begin
      wr_ok      = (state == IDLE) && w_wr_en;
      wr_weight  = wr_ok && (w_addr < AW'(NUM_INPUTS));
      wr_bias    = wr_ok && (w_addr == AW'(NUM_INPUTS));
      bias_eff   = wr_bias ? w_data : bias_reg;
      run_entry  = (state == IDLE) && start;
      acc_done   = (state == RUN) && (acc_cnt == AW'(NUM_INPUTS));
      cur_weight = weight_mem[acc_cnt[IW-1:0]];
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and output decode. Pops are issued whenever the FIFO has data
   // and fewer than NUM_INPUTS chunks have been requested, so a stalled FIFO
   // simply holds the FSM in RUN until the data arrives.
   always_comb begin
      state_next = state;
      fifo_rd_en = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            fifo_rd_en = !fifo_empty && (issue_cnt < AW'(NUM_INPUTS));
            if (acc_done) begin
               state_next = OUT;
            end
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Weight register file and bias. Everything clears on reset so a reset
   // leaves the neuron with an all-zero configuration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            weight_mem[i] <= '0;
         end
         bias_reg <= '0;
      end else begin
         if (wr_weight) begin
            weight_mem[w_addr[IW-1:0]] <= w_data;
         end
         if (wr_bias) begin
            bias_reg <= w_data;
         end
      end
   end

   // Issue/accumulate bookkeeping. The FIFO answers one cycle after a pop, so
   // rd_pend marks the cycle in which fifo_data carries a chunk; acc_cnt then
   // also selects the weight that pairs with that chunk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt <= '0;
         acc_cnt   <= '0;
         rd_pend   <= 1'b0;
      end else if (run_entry) begin
         issue_cnt <= '0;
         acc_cnt   <= '0;
         rd_pend   <= 1'b0;
      end else begin
         rd_pend <= fifo_rd_en;
         if (fifo_rd_en) begin
            issue_cnt <= issue_cnt + 1'b1;
         end
         if (rd_pend) begin
            acc_cnt <= acc_cnt + 1'b1;
         end
      end
   end

   mac_unit #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .load_bias (run_entry),
      .acc_en    (rd_pend),
      .bias      (bias_eff),
      .data      (fifo_data),
      .weight    (cur_weight),
      .acc       (acc)
   );

   // Activation/saturation of the final accumulator. Only the low OUT_WIDTH
   // bits of the shared-width function result are meaningful here.
   always_comb begin
      sat_full        = sat_relu(SAT_ACC_W'($signed(acc)), OUT_WIDTH);
      unused_sat_bits = ^sat_full[SAT_OUT_W-1:OUT_WIDTH];
   end

   // Result register, loaded on the edge that moves RUN to OUT and then held
   // untouched until the next evaluation completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
      end else if (acc_done) begin
         result <= sat_full[OUT_WIDTH-1:0];
      end
   end

endmodule
